// File: rtl/iso14443a_tag_demod.sv
`default_nettype none
// ============================================================================
//  Module   : iso14443a_tag_demod
//  Purpose  : ISO14443-A tag-to-reader Manchester frame decoder driven by the
//             per-slot subcarrier decision. Optional collision reporting is
//             built when ISO14443A_DEMOD_COLLISION_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module iso14443a_tag_demod (
  input  logic       osc_clk,
  input  logic       nrst,
  input  logic       enable,
  input  logic       slot_strobe,
  input  logic       curbit,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic [3:0] rx_nbits,
  output logic       rx_full,
  output logic       rx_par_ok,
  output logic       frame_busy,
  output logic       frame_end,
  output logic       coll,
  output logic [3:0] coll_bitpos
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SOF  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  localparam logic [2:0] c_LAST_SLOT = 3'd7;
  localparam logic [3:0] c_PAR_POS   = 4'd8;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_slot, w_slot_nxt;
  logic [2:0] r_cnt_a, w_cnt_a_nxt;
  logic [2:0] r_cnt_b, w_cnt_b_nxt;
  logic [3:0] r_pos, w_pos_nxt;
  logic [7:0] r_shift, w_shift_nxt;

  logic       w_rx_valid_nxt;
  logic [7:0] w_rx_data_nxt;
  logic [3:0] w_rx_nbits_nxt;
  logic       w_rx_full_nxt;
  logic       w_rx_par_ok_nxt;
  logic       w_busy_nxt;
  logic       w_frame_end_nxt;

  logic [2:0] w_cnt_a_acc;
  logic [2:0] w_cnt_b_acc;
  logic       w_a_mod;
  logic       w_b_mod;
  logic       w_sof_ok;
  logic       w_eof;
  logic       w_bit_val;
  logic       w_bit_eval;

  // Half counts including the slot being strobed now; saturate at 4.
  always_comb begin
    w_cnt_a_acc = r_cnt_a;
    w_cnt_b_acc = r_cnt_b;
    if (curbit) begin
      if (!r_slot[2] && (r_cnt_a < 3'd4)) w_cnt_a_acc = r_cnt_a + 3'd1;
      if (r_slot[2]  && (r_cnt_b < 3'd4)) w_cnt_b_acc = r_cnt_b + 3'd1;
    end
  end

  assign w_a_mod    = (w_cnt_a_acc >= 3'd2);
  assign w_b_mod    = (w_cnt_b_acc >= 3'd2);
  assign w_sof_ok   = (w_cnt_a_acc >= 3'd3) && !w_b_mod;
  assign w_eof      = !w_a_mod && !w_b_mod;
  // A modulated decodes as 1 whether or not B also carries subcarrier.
  assign w_bit_val  = w_a_mod;
  assign w_bit_eval = enable && slot_strobe && (r_state == S_DATA) && (r_slot == c_LAST_SLOT);

  always_comb begin
    w_state_nxt     = r_state;
    w_slot_nxt      = r_slot;
    w_cnt_a_nxt     = r_cnt_a;
    w_cnt_b_nxt     = r_cnt_b;
    w_pos_nxt       = r_pos;
    w_shift_nxt     = r_shift;
    w_rx_valid_nxt  = 1'b0;
    w_rx_data_nxt   = rx_data;
    w_rx_nbits_nxt  = rx_nbits;
    w_rx_full_nxt   = rx_full;
    w_rx_par_ok_nxt = rx_par_ok;
    w_busy_nxt      = frame_busy;
    w_frame_end_nxt = 1'b0;

    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_slot_nxt  = 3'd0;
      w_cnt_a_nxt = 3'd0;
      w_cnt_b_nxt = 3'd0;
      w_pos_nxt   = 4'd0;
      w_shift_nxt = 8'd0;
      w_busy_nxt  = 1'b0;
    end else if (slot_strobe) begin
      w_slot_nxt  = r_slot + 3'd1;
      w_cnt_a_nxt = w_cnt_a_acc;
      w_cnt_b_nxt = w_cnt_b_acc;
      case (r_state)
        S_IDLE: begin
          w_slot_nxt  = 3'd0;
          w_cnt_a_nxt = 3'd0;
          w_cnt_b_nxt = 3'd0;
          if (curbit) begin
            w_state_nxt = S_SOF;
            w_slot_nxt  = 3'd1;
            w_cnt_a_nxt = 3'd1;
          end
        end
        S_SOF: begin
          if (r_slot == c_LAST_SLOT) begin
            w_cnt_a_nxt = 3'd0;
            w_cnt_b_nxt = 3'd0;
            if (w_sof_ok) begin
              w_state_nxt = S_DATA;
              w_busy_nxt  = 1'b1;
              w_pos_nxt   = 4'd0;
              w_shift_nxt = 8'd0;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (r_slot == c_LAST_SLOT) begin
            w_cnt_a_nxt = 3'd0;
            w_cnt_b_nxt = 3'd0;
            if (w_eof) begin
              if (r_pos != 4'd0) begin
                w_rx_valid_nxt  = 1'b1;
                w_rx_data_nxt   = r_shift;
                w_rx_nbits_nxt  = r_pos;
                w_rx_full_nxt   = 1'b0;
                w_rx_par_ok_nxt = 1'b0;
              end
              w_frame_end_nxt = 1'b1;
              w_busy_nxt      = 1'b0;
              w_state_nxt     = S_IDLE;
              w_pos_nxt       = 4'd0;
              w_shift_nxt     = 8'd0;
            end else if (r_pos == c_PAR_POS) begin
              w_rx_valid_nxt  = 1'b1;
              w_rx_data_nxt   = r_shift;
              w_rx_nbits_nxt  = 4'd8;
              w_rx_full_nxt   = 1'b1;
              w_rx_par_ok_nxt = (^r_shift) ^ w_bit_val;
              w_pos_nxt       = 4'd0;
              w_shift_nxt     = 8'd0;
            end else begin
              w_shift_nxt[r_pos[2:0]] = w_bit_val;
              w_pos_nxt               = r_pos + 4'd1;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(negedge osc_clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= S_IDLE;
      r_slot     <= 3'd0;
      r_cnt_a    <= 3'd0;
      r_cnt_b    <= 3'd0;
      r_pos      <= 4'd0;
      r_shift    <= 8'd0;
      rx_valid   <= 1'b0;
      rx_data    <= 8'd0;
      rx_nbits   <= 4'd0;
      rx_full    <= 1'b0;
      rx_par_ok  <= 1'b0;
      frame_busy <= 1'b0;
      frame_end  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_slot     <= w_slot_nxt;
      r_cnt_a    <= w_cnt_a_nxt;
      r_cnt_b    <= w_cnt_b_nxt;
      r_pos      <= w_pos_nxt;
      r_shift    <= w_shift_nxt;
      rx_valid   <= w_rx_valid_nxt;
      rx_data    <= w_rx_data_nxt;
      rx_nbits   <= w_rx_nbits_nxt;
      rx_full    <= w_rx_full_nxt;
      rx_par_ok  <= w_rx_par_ok_nxt;
      frame_busy <= w_busy_nxt;
      frame_end  <= w_frame_end_nxt;
    end
  end

`ifdef ISO14443A_DEMOD_COLLISION_EN
  logic       w_collide;
  logic       w_coll_nxt;
  logic [3:0] w_coll_bitpos_nxt;

  assign w_collide = w_a_mod && w_b_mod;

  always_comb begin
    w_coll_nxt        = 1'b0;
    w_coll_bitpos_nxt = coll_bitpos;
    if (w_bit_eval && w_collide) begin
      w_coll_nxt        = 1'b1;
      w_coll_bitpos_nxt = r_pos;
    end
  end

  always_ff @(negedge osc_clk or negedge nrst) begin
    if (!nrst) begin
      coll        <= 1'b0;
      coll_bitpos <= 4'd0;
    end else begin
      coll        <= w_coll_nxt;
      coll_bitpos <= w_coll_bitpos_nxt;
    end
  end
`else
  logic w_unused;
  assign w_unused    = w_bit_eval;
  assign coll        = 1'b0;
  assign coll_bitpos = 4'd0;
`endif

endmodule
`default_nettype wire
